// File: rtl/fpu_operand_skid_if.sv
// Operand handshake bundle between the issue stage, the skid buffer and the first FPU register stage.
interface fpu_operand_skid_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3,
  parameter int unsigned TAGW  = 4
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OPW-1:0]   in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [OPW-1:0]   out_op;
  logic [TAGW-1:0]  out_tag;
  logic [1:0]       occupancy;

  modport slave (
    input  flush, in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_a, out_b, out_op, out_tag, occupancy
  );

  modport master (
    output flush, in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_op, out_tag, occupancy
  );
endinterface

// File: rtl/fpu_operand_skid.sv
// Two-entry skid buffer ahead of the FPU pipeline; tags each accepted operand pair
// and keeps in_ready registered so out_ready never reaches it combinationally.
module fpu_operand_skid #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3,
  parameter int unsigned TAGW  = 4
) (
  input logic               CK,
  input logic               RST,
  fpu_operand_skid_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
    logic [TAGW-1:0]  tag;
  } entry_t;

  state_t          state;
  entry_t          main_q;
  entry_t          skid_q;
  entry_t          in_entry;
  logic [TAGW-1:0] tag_cnt;
  logic            out_valid_q;
  logic            in_ready_q;
  logic [1:0]      occ_q;
  logic            acc;
  logic            rel;

  assign acc = bus.in_valid & in_ready_q;
  assign rel = out_valid_q & bus.out_ready;

  // Incoming entry carries the tag value before this acceptance bumps the counter
  assign in_entry = '{a: bus.in_a, b: bus.in_b, op: bus.in_op, tag: tag_cnt};

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = main_q.a;
  assign bus.out_b     = main_q.b;
  assign bus.out_op    = main_q.op;
  assign bus.out_tag   = main_q.tag;
  assign bus.occupancy = occ_q;

  // State, flag and data registers; flags are written alongside every state change
  always_ff @(posedge CK) begin
    if (RST) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      tag_cnt     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      if (acc && !bus.flush) begin
        tag_cnt <= tag_cnt + TAGW'(1);
      end

      if (bus.flush) begin
        state       <= EMPTY;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
        occ_q       <= 2'd0;
      end else begin
        case (state)
          EMPTY: begin
            if (acc) begin
              state       <= ONE;
              main_q      <= in_entry;
              out_valid_q <= 1'b1;
              occ_q       <= 2'd1;
            end
          end
          ONE: begin
            if (acc && !rel) begin
              state      <= FULL;
              skid_q     <= in_entry;
              in_ready_q <= 1'b0;
              occ_q      <= 2'd2;
            end else if (acc && rel) begin
              main_q <= in_entry;
            end else if (rel) begin
              state       <= EMPTY;
              out_valid_q <= 1'b0;
              occ_q       <= 2'd0;
            end
          end
          FULL: begin
            if (rel) begin
              state      <= ONE;
              main_q     <= skid_q;
              in_ready_q <= 1'b1;
              occ_q      <= 2'd1;
            end
          end
          default: begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occ_q       <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpu_operand_skid.sv
// Scoreboard bench for fpu_operand_skid: a FIFO-queue model of the buffer, directed scenarios then random traffic.
module tb_fpu_operand_skid;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned OPW   = 3;
  localparam int unsigned TAGW  = 4;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
    logic [TAGW-1:0]  tag;
  } exp_t;

  logic CK  = 1'b0;
  logic RST = 1'b1;

  fpu_operand_skid_if #(.WIDTH(WIDTH), .OPW(OPW), .TAGW(TAGW)) bus ();

  fpu_operand_skid #(.WIDTH(WIDTH), .OPW(OPW), .TAGW(TAGW)) dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CK = ~CK;

  exp_t q[$];
  int   model_tag = 0;
  int   checks    = 0;
  int   errors    = 0;
  bit   mon_en    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: flags against model occupancy, head entry against queue head, pop on transfer
  initial begin
    forever begin
      @(negedge CK);
      if (mon_en) begin
        chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        chk("in_ready",  64'(bus.in_ready),  64'(q.size() < 2));
        if (q.size() != 0) begin
          chk("out_a",   64'(bus.out_a),   64'(q[0].a));
          chk("out_b",   64'(bus.out_b),   64'(q[0].b));
          chk("out_op",  64'(bus.out_op),  64'(q[0].op));
          chk("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
          if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) void'(q.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; the model is updated after the monitor has taken this cycle's transfer
  task automatic cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [OPW-1:0] op, input logic ordy, input logic fl, input logic rs);
    exp_t e;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_op     = op;
    bus.out_ready = ordy;
    bus.flush     = fl;
    RST           = rs;
    @(negedge CK);
    #1;
    if (rs) begin
      q.delete();
      model_tag = 0;
    end else if (fl) begin
      q.delete();
    end else if (v && bus.in_ready === 1'b1) begin
      e.a = a; e.b = b; e.op = op; e.tag = TAGW'(model_tag);
      q.push_back(e);
      model_tag = (model_tag + 1) % (1 << TAGW);
    end
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push(input logic [WIDTH-1:0] a, input logic ordy);
    cycle(1'b1, a, ~a, OPW'(a), ordy, 1'b0, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;

    // Reset state then a single transfer
    do_reset();
    mon_en = 1'b1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    cycle(1'b1, 32'h3F800000, 32'h40000000, 3'd2, 1'b1, 1'b0, 1'b0);
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_a", 64'(bus.out_a), 64'h3F800000);
    chk("t1_b", 64'(bus.out_b), 64'h40000000);
    chk("t1_op", 64'(bus.out_op), 64'd2);
    chk("t1_tag", 64'(bus.out_tag), 64'd0);
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("t1_drain_valid", 64'(bus.out_valid), 64'd0);
    chk("t1_drain_occ", 64'(bus.occupancy), 64'd0);

    // Backpressure fill and hold
    do_reset();
    push(32'hAAAA0001, 1'b0);
    push(32'hBBBB0002, 1'b0);
    chk("t2_occ", 64'(bus.occupancy), 64'd2);
    chk("t2_in_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'hDEAD0000, '0, '0, 1'b0, 1'b0, 1'b0);
      chk("t2_hold_a", 64'(bus.out_a), 64'hAAAA0001);
    end
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("t2_second_a", 64'(bus.out_a), 64'hBBBB0002);
    chk("t2_second_tag", 64'(bus.out_tag), 64'd1);
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("t2_drain_ready", 64'(bus.in_ready), 64'd1);

    // Streaming at full rate
    do_reset();
    for (int i = 0; i < 20; i++) begin
      push(WIDTH'(i), 1'b1);
      chk("t3_a", 64'(bus.out_a), 64'(i));
      chk("t3_occ", 64'(bus.occupancy), 64'd1);
    end
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Tag wrap, then a push under flush must not consume a tag
    do_reset();
    for (int i = 0; i < 17; i++) begin
      push(WIDTH'(100 + i), 1'b1);
      chk("t4_tag", 64'(bus.out_tag), 64'(i % 16));
    end
    cycle(1'b1, 32'h0BAD0BAD, '0, '0, 1'b1, 1'b1, 1'b0);
    push(32'h00000777, 1'b1);
    chk("t4_after_flush_tag", 64'(bus.out_tag), 64'd1);
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Flush while full with a concurrent push
    do_reset();
    push(32'h11111111, 1'b0);
    push(32'h22222222, 1'b0);
    cycle(1'b1, 32'h33333333, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("t5_occ", 64'(bus.occupancy), 64'd0);
    chk("t5_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_ready", 64'(bus.in_ready), 64'd1);
    push(32'h44444444, 1'b0);
    chk("t5_next_tag", 64'(bus.out_tag), 64'd2);
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream with flush and a push
    push(32'h55555555, 1'b0);
    push(32'h66666666, 1'b0);
    cycle(1'b1, 32'h77777777, 32'h1, 3'd5, 1'b0, 1'b1, 1'b1);
    chk("t6_occ", 64'(bus.occupancy), 64'd0);
    chk("t6_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_ready", 64'(bus.in_ready), 64'd1);
    chk("t6_a", 64'(bus.out_a), 64'd0);
    chk("t6_b", 64'(bus.out_b), 64'd0);
    chk("t6_op", 64'(bus.out_op), 64'd0);
    chk("t6_tag", 64'(bus.out_tag), 64'd0);
    push(32'h88888888, 1'b0);
    chk("t6_next_tag", 64'(bus.out_tag), 64'd0);
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(1)), $urandom, $urandom, OPW'($urandom),
            1'($urandom_range(3) != 0), $urandom_range(24) == 0, $urandom_range(299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_operand_skid.md
Name: fpu_operand_skid

Overview:
- Two-entry skid buffer that sits directly upstream of the FPU datapath pipeline registers.
- Accepts operand pairs plus an opcode over a valid/ready handshake and stamps each accepted transaction with a wrapping tag.
- Presents entries in order to the first FPU register stage.
- in_ready is a registered signal, so there is no combinational path from out_ready to in_ready. Full throughput is kept under backpressure.

Parameters:
- WIDTH, 32, operand width in bits (in_a/in_b/out_a/out_b)
- OPW, 3, opcode width in bits
- TAGW, 4, transaction tag width in bits; the tag wraps modulo 2^TAGW

Ports:
- CK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous reset, active-high
- flush  input  1  synchronous discard of all buffered entries
- in_valid  input  1  upstream transaction valid
- in_ready  output  1  buffer can accept (registered)
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  OPW  opcode
- out_valid  output  1  head entry valid
- out_ready  input  1  FPU stage accepts head entry
- out_a  output  WIDTH  head operand A
- out_b  output  WIDTH  head operand B
- out_op  output  OPW  head opcode
- out_tag  output  TAGW  tag of head entry
- occupancy  output  2  entries held (0..2)

Behaviour:
- Definitions: acc = in_valid & in_ready; rel = out_valid & out_ready.
- State machine EMPTY / ONE / FULL with a main register (drives out_*) and a skid register.
- Outputs are derived from state: out_valid = (state != EMPTY); in_ready = (state != FULL), held in a flop; occupancy is 0 / 1 / 2.
- EMPTY:
  - acc -> ONE; main <= {in_a, in_b, in_op, tag_cnt}.
- ONE:
  - acc & !rel -> FULL; skid <= input.
  - acc & rel -> ONE; main <= input.
  - !acc & rel -> EMPTY.
  - Otherwise hold.
- FULL:
  - rel -> ONE; main <= skid.
  - Otherwise hold.
  - acc cannot occur because in_ready = 0.
- Latency: a transaction accepted at edge N is on out_* with out_valid = 1 after edge N (one cycle).
- Ordering is strict FIFO. No entry is dropped or duplicated except by flush or RST.
- Stability: while out_valid & !out_ready, out_a/out_b/out_op/out_tag hold their values.
- Tag counter tag_cnt:
  - Increments by 1 on every acc and wraps from 2^TAGW-1 to 0.
  - The accepted entry carries the pre-increment value.
- flush (when RST = 0):
  - Next state is EMPTY; in_ready = 1 and out_valid = 0 after the edge.
  - A simultaneous acc is discarded and does not advance tag_cnt.
  - A simultaneous rel still counts as a transfer to the consumer.
  - tag_cnt is otherwise preserved.
- RST has priority over flush and over all handshakes. After an RST edge:
  - state = EMPTY, out_valid = 0, in_ready = 1, occupancy = 0;
  - out_a/out_b/out_op/out_tag = 0, skid contents = 0, tag_cnt = 0.
- Reset mid-operation discards all entries. Any in_valid in the reset cycle is ignored.
- Data registers update only on the transitions listed above. Inputs are don't-care when in_valid = 0.

Test Plan:
1. Reset then single transfer: RST 1 for 2 cycles; in_valid = 1, in_a = 0x3F800000, in_b = 0x40000000, in_op = 2 for one cycle; out_ready = 1 -> next cycle out_valid = 1, out_a = 0x3F800000, out_b = 0x40000000, out_op = 2, out_tag = 0. Following cycle out_valid = 0, occupancy = 0.
2. Backpressure fill: out_ready = 0; push A (tag 0) then B (tag 1) -> occupancy = 2, in_ready = 0, out_a holds A for 5 stall cycles. Raise out_ready -> A then B on consecutive cycles with tags 0, 1; then in_ready = 1.
3. Streaming throughput: in_valid = 1 and out_ready = 1 for 20 cycles with in_a = 0..19 -> out_a = 0..19 on consecutive cycles; occupancy stays 1; in_ready never drops.
4. Tag wrap: accept 17 transactions with TAGW = 4 -> tags 0..15 then 0. A push concurrent with flush does not consume a tag value.
5. Flush while FULL with in_valid = 1: flush = 1 for one cycle -> next cycle occupancy = 0, out_valid = 0, in_ready = 1. The next accepted entry gets tag 2, the tag following the two buffered entries.
6. Reset mid-stream: occupancy = 2, assert RST together with flush and in_valid -> after the edge all outputs are 0, in_ready = 1, and the next accepted entry has tag 0.
